// File: rtl/mips_pkg.sv
// Shared MIPS-Lite definitions: opcodes, instruction layout, forwarding
// select and sequencer state encodings, plus source-operand decode helpers.
package mips_pkg;

   localparam logic [5:0] OP_ADD  = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_SUBI = 6'h03;
   localparam logic [5:0] OP_MUL  = 6'h04;
   localparam logic [5:0] OP_MULI = 6'h05;
   localparam logic [5:0] OP_OR   = 6'h06;
   localparam logic [5:0] OP_ORI  = 6'h07;
   localparam logic [5:0] OP_AND  = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h09;
   localparam logic [5:0] OP_XOR  = 6'h0A;
   localparam logic [5:0] OP_XORI = 6'h0B;
   localparam logic [5:0] OP_LDW  = 6'h0C;
   localparam logic [5:0] OP_STW  = 6'h0D;
   localparam logic [5:0] OP_BZ   = 6'h0E;
   localparam logic [5:0] OP_BEQ  = 6'h0F;
   localparam logic [5:0] OP_JR   = 6'h10;
   localparam logic [5:0] OP_HALT = 6'h11;

   // Instruction word layout; rd overlaps imm[15:11].
   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] imm;
   } instruct_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      DRAIN  = 2'b01,
      HALTED = 2'b10
   } seq_state_t;

   // Every defined opcode except HALT reads rs (0x00..0x10 contiguous).
   function automatic logic reads_rs(input logic [5:0] op);
      return (op <= OP_JR);
   endfunction

   // Only R-type ALU ops, STW and BEQ read rt.
   function automatic logic reads_rt(input logic [5:0] op);
      logic r;
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR, OP_STW, OP_BEQ: r = 1'b1;
         default:                                                        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding source select for one EX operand; MEM result beats WB data,
// and r0 is never forwarded.
module fwd_unit
   import mips_pkg::*;
(
   input  logic [4:0] ex_src,
   input  logic [4:0] mem_dest,
   input  logic       mem_regwrite,
   input  logic [4:0] wb_dest,
   input  logic       wb_regwrite,
   output logic [1:0] fwd_sel
);

   fwd_sel_t sel;

   // Pick the youngest in-flight producer of ex_src.
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves sel unassigned (that would infer a latch).
      sel = FWD_RF;
      if (mem_regwrite && (mem_dest != 5'd0) && (mem_dest == ex_src))
         sel = FWD_MEM;
      else if (wb_regwrite && (wb_dest != 5'd0) && (wb_dest == ex_src))
         sel = FWD_WB;
   end

   assign fwd_sel = sel;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: load-use stalls, redirect squashing,
// EX operand forwarding, HALT drain and stall/flush performance counters.
module hazard_sequencer
   import mips_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int DRAIN_CYC = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      id_instr,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       ex_dest,
   input  logic             ex_regWrite,
   input  logic             ex_isLoad,
   input  logic             ex_redirect,
   input  logic [4:0]       mem_dest,
   input  logic             mem_regWrite,
   input  logic [4:0]       wb_dest,
   input  logic             wb_regWrite,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Drain counter only has to hold DRAIN_CYC-1.
   localparam int            DC_W        = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DC_W-1:0] DRAIN_START = DC_W'(DRAIN_CYC - 1);

   seq_state_t      state;
   logic [DC_W-1:0] drain_cnt;

   instruct_t id;
   logic      unused_imm;
   logic      uses_rs;
   logic      uses_rt;
   logic      load_use;
   logic      is_halt;

   logic      redirect_evt;
   logic      stall_evt;
   logic      halt_evt;

   logic [1:0] fwd_a_raw;
   logic [1:0] fwd_b_raw;

   assign id         = instruct_t'(id_instr);
   assign unused_imm = ^id.imm;

   // r0 reads are hardwired zero, so they can never depend on a load.
   assign uses_rs  = reads_rs(id.opcode) && (id.rs != 5'd0);
   assign uses_rt  = reads_rt(id.opcode) && (id.rt != 5'd0);
   assign load_use = ex_isLoad && ex_regWrite && (ex_dest != 5'd0) &&
                     ((uses_rs && (ex_dest == id.rs)) || (uses_rt && (ex_dest == id.rt)));
   assign is_halt  = (id.opcode == OP_HALT);

   fwd_unit u_fwd_a (
      .ex_src       (ex_rs),
      .mem_dest     (mem_dest),
      .mem_regwrite (mem_regWrite),
      .wb_dest      (wb_dest),
      .wb_regwrite  (wb_regWrite),
      .fwd_sel      (fwd_a_raw)
   );

   fwd_unit u_fwd_b (
      .ex_src       (ex_rt),
      .mem_dest     (mem_dest),
      .mem_regwrite (mem_regWrite),
      .wb_dest      (wb_dest),
      .wb_regwrite  (wb_regWrite),
      .fwd_sel      (fwd_b_raw)
   );

   // Forwarding ignores sequencer state but is held at 0 during reset.
   assign fwd_a = rst_n ? fwd_a_raw : 2'b00;
   assign fwd_b = rst_n ? fwd_b_raw : 2'b00;

   // Pipeline control from state and hazards; redirect beats load-use beats HALT.
   always_comb begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      redirect_evt = 1'b0;
      stall_evt    = 1'b0;
      halt_evt     = 1'b0;
      if (rst_n) begin
         case (state)
            RUN: begin
               if (ex_redirect) begin
                  ifid_flush   = 1'b1;
                  idex_bubble  = 1'b1;
                  redirect_evt = 1'b1;
               end else if (load_use) begin
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  idex_bubble = 1'b1;
                  stall_evt   = 1'b1;
               end else if (is_halt) begin
                  // HALT itself flows into ID/EX; only fetch is frozen.
                  pc_stall   = 1'b1;
                  ifid_flush = 1'b1;
                  halt_evt   = 1'b1;
               end
            end
            DRAIN, HALTED: begin
               pc_stall    = 1'b1;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Sequencer state, drain countdown, halted flag and performance counters.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state     <= RUN;
         drain_cnt <= '0;
         halted    <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (redirect_evt) flush_cnt <= flush_cnt + CNT_W'(1);
               if (stall_evt)    stall_cnt <= stall_cnt + CNT_W'(1);
               if (halt_evt) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_START;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DC_W'(1);
               end
            end
            HALTED: ;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: the stimulus process drives one
// directed vector per cycle and queues its hand-computed response; a monitor
// on the falling edge pops and compares.
module tb_hazard_sequencer;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] id_instr = '0;
   logic [4:0]  ex_rs = '0, ex_rt = '0, ex_dest = '0;
   logic        ex_regWrite = 1'b0, ex_isLoad = 1'b0, ex_redirect = 1'b0;
   logic [4:0]  mem_dest = '0, wb_dest = '0;
   logic        mem_regWrite = 1'b0, wb_regWrite = 1'b0;

   logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, halted;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] stall_cnt, flush_cnt;

   typedef struct {
      string       name;
      logic [8:0]  ctrl;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   hazard_sequencer #(.CNT_W(32), .DRAIN_CYC(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_instr     (id_instr),
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .ex_dest      (ex_dest),
      .ex_regWrite  (ex_regWrite),
      .ex_isLoad    (ex_isLoad),
      .ex_redirect  (ex_redirect),
      .mem_dest     (mem_dest),
      .mem_regWrite (mem_regWrite),
      .wb_dest      (wb_dest),
      .wb_regWrite  (wb_regWrite),
      .pc_stall     (pc_stall),
      .ifid_stall   (ifid_stall),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .halted       (halted),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   // Expected response for the vector just driven.
   // ctrl = {pc_stall, ifid_stall, ifid_flush, idex_bubble, fwd_a, fwd_b, halted}
   task automatic expect_row(input string name, input logic ps, input logic is_, input logic fl,
                             input logic bub, input logic [1:0] fa, input logic [1:0] fb,
                             input logic h, input int sc, input int fc);
      exp_t e;
      e.name = name;
      e.ctrl = {ps, is_, fl, bub, fa, fb, h};
      e.sc   = sc;
      e.fc   = fc;
      exp_q.push_back(e);
   endtask

   // Advance to just after the next rising edge and return inputs to idle.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      id_instr     = '0;
      ex_rs        = '0;
      ex_rt        = '0;
      ex_dest      = '0;
      ex_regWrite  = 1'b0;
      ex_isLoad    = 1'b0;
      ex_redirect  = 1'b0;
      mem_dest     = '0;
      mem_regWrite = 1'b0;
      wb_dest      = '0;
      wb_regWrite  = 1'b0;
   endtask

   task automatic load_in_ex(input logic [4:0] dest);
      ex_isLoad   = 1'b1;
      ex_regWrite = 1'b1;
      ex_dest     = dest;
   endtask

   // Monitor: compare DUT outputs against the queued expectation each cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.name, "_ctrl"}, {23'd0, pc_stall, ifid_stall, ifid_flush, idex_bubble,
                                   fwd_a, fwd_b, halted}, {23'd0, e.ctrl});
         check({e.name, "_stall_cnt"}, stall_cnt, e.sc);
         check({e.name, "_flush_cnt"}, flush_cnt, e.fc);
      end
   end

   initial begin
      // Reset cycle with hazard, redirect and forwarding conditions all present.
      next_cycle();
      rst_n = 1'b0; load_in_ex(5'd3); id_instr = enc(OP_ADD, 5'd3, 5'd5, 5'd4);
      ex_redirect = 1'b1; ex_rs = 5'd7; mem_dest = 5'd7; mem_regWrite = 1'b1;
      expect_row("reset_gate", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

      next_cycle();
      load_in_ex(5'd3); id_instr = enc(OP_ADD, 5'd3, 5'd5, 5'd4);
      expect_row("load_use", 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);

      next_cycle();
      mem_dest = 5'd3; mem_regWrite = 1'b1;
      ex_rs = 5'd3; ex_rt = 5'd5; ex_dest = 5'd4; ex_regWrite = 1'b1;
      id_instr = enc(OP_ADD, 5'd1, 5'd2, 5'd6);
      expect_row("ld_fwd_mem", 0, 0, 0, 0, 2'b01, 2'b00, 0, 1, 0);

      next_cycle();
      ex_redirect = 1'b1; load_in_ex(5'd3); id_instr = enc(OP_ADD, 5'd3, 5'd5, 5'd4);
      expect_row("redirect_hazard", 0, 0, 1, 1, 2'b00, 2'b00, 0, 1, 0);

      next_cycle();
      expect_row("after_redirect", 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1);

      next_cycle();
      mem_dest = 5'd7; wb_dest = 5'd7; mem_regWrite = 1'b1; wb_regWrite = 1'b1;
      ex_rs = 5'd7; ex_rt = 5'd7;
      expect_row("fwd_mem_prio", 0, 0, 0, 0, 2'b01, 2'b01, 0, 1, 1);

      next_cycle();
      mem_dest = 5'd7; wb_dest = 5'd7; wb_regWrite = 1'b1;
      ex_rs = 5'd7; ex_rt = 5'd7;
      expect_row("fwd_wb", 0, 0, 0, 0, 2'b10, 2'b10, 0, 1, 1);

      next_cycle();
      mem_regWrite = 1'b1; wb_regWrite = 1'b1;
      expect_row("fwd_r0", 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1);

      next_cycle();
      ex_rs = 5'd7; ex_rt = 5'd9; mem_dest = 5'd9; mem_regWrite = 1'b1;
      wb_dest = 5'd7; wb_regWrite = 1'b1;
      expect_row("fwd_mixed", 0, 0, 0, 0, 2'b10, 2'b01, 0, 1, 1);

      next_cycle();
      load_in_ex(5'd0); id_instr = enc(OP_ADD, 5'd0, 5'd0, 5'd4);
      expect_row("ldw_r0", 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1);

      next_cycle();
      load_in_ex(5'd5); id_instr = enc(OP_ADDI, 5'd1, 5'd5, 5'd0);
      expect_row("itype_rt_ignored", 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1);

      next_cycle();
      load_in_ex(5'd5); id_instr = enc(OP_BEQ, 5'd1, 5'd5, 5'd0);
      expect_row("beq_rt_hazard", 1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 1);

      next_cycle();
      load_in_ex(5'd5); id_instr = enc(6'h12, 5'd5, 5'd5, 5'd0);
      expect_row("undef_op", 0, 0, 0, 0, 2'b00, 2'b00, 0, 2, 1);

      next_cycle();
      ex_redirect = 1'b1; id_instr = enc(OP_HALT, 5'd0, 5'd0, 5'd0);
      expect_row("halt_redirect", 0, 0, 1, 1, 2'b00, 2'b00, 0, 2, 1);

      next_cycle();
      expect_row("no_drain", 0, 0, 0, 0, 2'b00, 2'b00, 0, 2, 2);

      next_cycle();
      id_instr = enc(OP_HALT, 5'd0, 5'd0, 5'd0);
      expect_row("halt_id", 1, 0, 1, 0, 2'b00, 2'b00, 0, 2, 2);

      for (int i = 0; i < 3; i++) begin
         next_cycle();
         ex_redirect = 1'b1;
         expect_row($sformatf("drain_%0d", i), 1, 0, 1, 1, 2'b00, 2'b00, 0, 2, 2);
      end

      for (int i = 0; i < 20; i++) begin
         next_cycle();
         ex_redirect = 1'b1; load_in_ex(5'd3); id_instr = enc(OP_ADD, 5'd3, 5'd5, 5'd4);
         if (i == 0) begin
            ex_rs = 5'd7; mem_dest = 5'd7; mem_regWrite = 1'b1;
            expect_row("halted_fwd", 1, 0, 1, 1, 2'b01, 2'b00, 1, 2, 2);
         end else begin
            expect_row($sformatf("halted_%0d", i), 1, 0, 1, 1, 2'b00, 2'b00, 1, 2, 2);
         end
      end

      next_cycle();
      rst_n = 1'b0;
      expect_row("reset_from_halt", 0, 0, 0, 0, 2'b00, 2'b00, 1, 2, 2);

      next_cycle();
      expect_row("after_reset", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

      next_cycle();
      id_instr = enc(OP_HALT, 5'd0, 5'd0, 5'd0);
      expect_row("halt_again", 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0);

      next_cycle();
      expect_row("drain_again", 1, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0);

      next_cycle();
      rst_n = 1'b0; ex_redirect = 1'b1;
      expect_row("reset_mid_drain", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

      next_cycle();
      id_instr = enc(OP_ADD, 5'd3, 5'd5, 5'd4);
      expect_row("run_after_reset", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

      next_cycle();
      load_in_ex(5'd9); id_instr = enc(OP_ADD, 5'd3, 5'd5, 5'd4);
      expect_row("add_no_match", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

      next_cycle();
      load_in_ex(5'd3); id_instr = enc(OP_ADD, 5'd3, 5'd5, 5'd4);
      expect_row("load_use_post", 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);

      next_cycle();
      expect_row("count_post", 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);

      // Let the monitor drain the scoreboard, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline sequencing controller for the 5-stage MIPS-Lite core with forwarding; sits beside the decode-stage controller.
- Detects load-use hazards and inserts bubbles. Squashes younger instructions on a taken branch or JR redirect from EX.
- Selects forwarding sources for the EX operands.
- Runs the HALT drain sequence and keeps stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the performance counters.
- DRAIN_CYC, 3, cycles from HALT leaving ID until it retires from WB.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_instr  in  32  Instruct in ID stage: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0]
- ex_rs  in  5  rs of the instruction in EX
- ex_rt  in  5  rt of the instruction in EX
- ex_dest  in  5  destination register of the EX instruction
- ex_regWrite  in  1  EX instruction writes the register file
- ex_isLoad  in  1  EX instruction is LDW
- ex_redirect  in  1  taken BZ/BEQ or JR resolved in EX
- mem_dest  in  5  destination register of the MEM instruction
- mem_regWrite  in  1  MEM instruction writes the register file
- wb_dest  in  5  destination register of the WB instruction
- wb_regWrite  in  1  WB instruction writes the register file
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load NOP (all control 0) into ID/EX
- fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM ALU result, 10 WB data
- fwd_b  out  2  EX operand B select, same encoding
- halted  out  1  core stopped
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  redirect events

Behaviour:
- Reset (rst_n=0 at posedge): state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, halted=0.
- During reset, all combinational outputs are 0.
- ID source decode:
  - R-type ALU ops (0x00,02,04,06,08,0A), STW 0x0D and BEQ 0x0F read rs and rt.
  - I-type ALU ops (odd 0x01–0x0B), LDW 0x0C, BZ 0x0E and JR 0x10 read rs only.
  - HALT 0x11 and undefined opcodes read nothing.
- Register r0 never causes a hazard or forward.
- State RUN, priority order:
  1. ex_redirect=1: ifid_flush=1, idex_bubble=1, no stall; flush_cnt+1. This holds even if ID holds a hazard or HALT; the ID instruction is squashed.
  2. Load-use (ex_isLoad & ex_regWrite & ex_dest≠0 & ex_dest matches a used ID source): pc_stall=1, ifid_stall=1, idex_bubble=1; stall_cnt+1. Exactly one bubble per hazard, because the next cycle the load is in MEM.
  3. id opcode=0x11: idex passes HALT normally; pc_stall=1, ifid_flush=1; next state DRAIN, counter=DRAIN_CYC-1.
  4. Otherwise all control outputs 0.
- State DRAIN:
  - pc_stall=1 and ifid_flush=1 every cycle; idex_bubble=1 (ID holds a NOP).
  - Counter decrements each cycle; at 0, next state HALTED.
  - ex_redirect cannot occur here (EX holds HALT or bubbles) and is ignored.
- State HALTED: halted=1, pc_stall=1, ifid_flush=1, idex_bubble=1. Stays until reset.
- Reset mid-DRAIN returns to RUN the next cycle.
- Forwarding is combinational and state-independent:
  - fwd_a=01 if mem_regWrite & mem_dest≠0 & mem_dest==ex_rs.
  - Else fwd_a=10 if wb_regWrite & wb_dest≠0 & wb_dest==ex_rs.
  - Else fwd_a=00. MEM has priority over WB.
  - fwd_b uses the same rule with ex_rt.
- Counters wrap modulo 2^CNT_W. They are frozen in HALTED.
- Control outputs are combinational from state and inputs. state, counter and halted are registered.

Decomposition:
- Shared package mips_pkg: opcode localparams (OP_ADD…OP_HALT), fwd_sel_t enum {FWD_RF, FWD_MEM, FWD_WB}, seq_state_t enum {RUN, DRAIN, HALTED}, and reuse of Instruct.
- One sub-module, fwd_unit: purely combinational, instantiated once per operand.

Test Plan:
- Load-use: LDW r3 in EX (ex_isLoad=1, ex_dest=3), ADD r4,r3,r5 in ID.
  - Exactly one cycle of pc_stall=ifid_stall=idex_bubble=1; stall_cnt=1.
  - Next cycle (load in MEM, ADD in EX with ex_rs=3): fwd_a=01.
- Redirect + hazard: ex_redirect=1 with the load-use condition also true.
  - ifid_flush=idex_bubble=1, pc_stall=0; flush_cnt=1, stall_cnt unchanged.
- Forward priority: mem_dest=wb_dest=7, both regWrite=1, ex_rs=ex_rt=7 → fwd_a=fwd_b=01.
  - With mem_regWrite=0 → 10.
  - With dest=0 → 00.
- HALT: opcode 0x11 in ID.
  - pc_stall from that cycle.
  - halted=1 exactly DRAIN_CYC+1 cycles later and held for 20 cycles.
  - Counters frozen.
- Reset mid-DRAIN: rst_n=0 for one cycle.
  - Outputs 0, state RUN, counters 0, halted=0.
  - A normal ADD afterwards produces no stall.
- No false hazard: LDW r0 in EX with ADD reading r0 → no stall. HALT in ID with ex_redirect=1 → no DRAIN entered.
